// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory initiator: size codes, FSM states
// and the alignment rule used to reject bad requests before any memory access.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // The reserved size code is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts/extends a sub-word on loads and merges a
// sub-word into the old memory word for read-modify-write stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
    byte_shift  = {~offset, 3'b000};
    half_shift  = {~offset[1], 4'b0000};
    lane_b      = 8'(rd_word >> byte_shift);
    lane_h      = 16'(rd_word >> half_shift);
    load_data   = rd_word;
    merged_word = old_word;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{is_signed & lane_b[7]}}, lane_b};
        merged_word = (old_word & ~(32'h0000_00FF << byte_shift)) |
                      ({24'd0, wdata[7:0]} << byte_shift);
      end
      SZ_HALF: begin
        load_data   = {{16{is_signed & lane_h[15]}}, lane_h};
        merged_word = (old_word & ~(32'h0000_FFFF << half_shift)) |
                      ({16'd0, wdata[15:0]} << half_shift);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator toward the data memory: one request at a time, sub-word
// stores as read-modify-write, response held until the core accepts it.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       Address,
  output logic [31:0]       WriteData,
  input  logic [31:0]       ReadData
);

  localparam int CNT_W = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_error_q, resp_error_d;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  mem_lane_align u_align (
    .rd_word     (ReadData),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_signed   (signed_q),
    .old_word    (ReadData),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (req_write && req_size == SZ_WORD) begin
            state_d = ST_WR;
            word_d  = req_wdata;
          end else begin
            state_d = ST_RD;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            state_d = ST_WR;
            word_d  = merged_word;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            resp_rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'd0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_error_d = 1'b0;
          resp_rdata_d = 32'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      word_q       <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Ready is gated by rst_n so it reads 0 while reset is held.
  assign req_ready  = rst_n && (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign MemRead    = (state_q == ST_RD);
  assign MemWrite   = (state_q == ST_WR);
  assign Address    = 32'(addr_q[ADDR_W-1:2]);
  assign WriteData  = word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// loads/stores checked against a byte-level reference model of memory.
module tb_mem_access_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .MemRead(MemRead),
    .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData)
  );

  // Memory device seen by the DUT, plus activity counters.
  logic [31:0] mem [16] = '{default: 32'd0};
  logic [31:0] ref_mem [16] = '{default: 32'd0};
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] wr_addr = 32'd0, wr_data = 32'd0, rd_addr = 32'd0;

  assign ReadData = mem[Address[3:0]];

  always @(posedge clk) begin
    if (MemRead) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= Address;
    end
    if (MemWrite) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= Address;
      wr_data <= WriteData;
      mem[Address[3:0]] <= WriteData;
    end
    if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
  end

  // Reference model: memory as big-endian bytes, computed arithmetically.
  function automatic bit ref_misal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic int exp_lat(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (ref_misal(sz, a)) return 1;
    if (!w) return LAT + 1;
    if (sz == 2'd2) return 2;
    return LAT + 2;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                           input logic [1:0] sz, input bit sg);
    longint b[4];
    longint v;
    for (int i = 0; i < 4; i++) b[i] = (longint'(word) / (64'd1 << (24 - 8 * i))) % 256;
    if (sz == 2'd0) begin
      v = b[off];
      if (sg && v >= 128) v = v - 256;
      return 32'(v);
    end
    if (sz == 2'd1) begin
      v = b[off] * 256 + b[off + 1];
      if (sg && v >= 32768) v = v - 65536;
      return 32'(v);
    end
    return word;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input int off,
                                            input logic [1:0] sz, input logic [31:0] wd);
    longint b[4];
    if (sz == 2'd2) return wd;
    for (int i = 0; i < 4; i++) b[i] = (longint'(old) / (64'd1 << (24 - 8 * i))) % 256;
    if (sz == 2'd0) begin
      b[off] = longint'(wd) % 256;
    end else begin
      b[off]     = (longint'(wd) / 256) % 256;
      b[off + 1] = longint'(wd) % 256;
    end
    return 32'(b[0] * 16777216 + b[1] * 65536 + b[2] * 256 + b[3]);
  endfunction

  // Drives one request, waits for the accept edge and for resp_valid (bounded).
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output int r0, output int w0, output int b0);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    r0 = rd_cnt; w0 = wr_cnt; b0 = both_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_resp();
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_resp got=%b/%b/%h want=0/0/0", resp_valid, resp_error, resp_rdata); end
    checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b/%b want=0/0", MemRead, MemWrite); end
    checks++; if (Address !== 32'd0 || WriteData !== 32'd0) begin failures++; $display("FAIL reset_addr_data got=%h/%h want=0/0", Address, WriteData); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_word_store_load();
    int lat, r0, w0, b0;
    logic [31:0] rd;
    issue(1'b1, 2'd2, 1'b0, 32'h0C, 32'h5555_5540, lat, r0, w0, b0);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d want=2", lat); end
    finish_resp();
    checks++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin failures++; $display("FAIL sw_cycles got wr=%0d rd=%0d want wr=1 rd=0", wr_cnt - w0, rd_cnt - r0); end
    checks++; if (wr_addr !== 32'd3 || wr_data !== 32'h5555_5540) begin failures++; $display("FAIL sw_write got=%h/%h want=3/55555540", wr_addr, wr_data); end
    ref_mem[3] = 32'h5555_5540;
    issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, lat, r0, w0, b0);
    rd = resp_rdata;
    checks++; if (lat !== LAT + 1) begin failures++; $display("FAIL lw_latency got=%0d want=%0d", lat, LAT + 1); end
    checks++; if (rd !== 32'h5555_5540) begin failures++; $display("FAIL lw_data got=%h want=55555540", rd); end
    finish_resp();
    checks++; if (rd_cnt - r0 !== LAT || rd_addr !== 32'd3) begin failures++; $display("FAIL lw_read got cycles=%0d addr=%h want %0d/3", rd_cnt - r0, rd_addr, LAT); end
  endtask

  task automatic test_byte_loads();
    int lat, r0, w0, b0;
    logic [31:0] rd;
    issue(1'b1, 2'd2, 1'b0, 32'h1C, 32'h12F4_5678, lat, r0, w0, b0);
    finish_resp();
    ref_mem[7] = 32'h12F4_5678;
    issue(1'b0, 2'd0, 1'b1, 32'h1D, 32'd0, lat, r0, w0, b0); rd = resp_rdata; finish_resp();
    checks++; if (rd !== 32'hFFFF_FFF4) begin failures++; $display("FAIL lb got=%h want=fffffff4", rd); end
    issue(1'b0, 2'd0, 1'b0, 32'h1D, 32'd0, lat, r0, w0, b0); rd = resp_rdata; finish_resp();
    checks++; if (rd !== 32'h0000_00F4) begin failures++; $display("FAIL lbu got=%h want=000000f4", rd); end
    issue(1'b0, 2'd1, 1'b1, 32'h1E, 32'd0, lat, r0, w0, b0); rd = resp_rdata; finish_resp();
    checks++; if (rd !== 32'h0000_5678) begin failures++; $display("FAIL lh got=%h want=00005678", rd); end
  endtask

  task automatic test_rmw();
    int lat, r0, w0, b0;
    issue(1'b1, 2'd2, 1'b0, 32'h1C, 32'h1122_3344, lat, r0, w0, b0);
    finish_resp();
    issue(1'b1, 2'd0, 1'b0, 32'h1F, 32'h0000_00AA, lat, r0, w0, b0);
    checks++; if (lat !== LAT + 2) begin failures++; $display("FAIL sb_latency got=%0d want=%0d", lat, LAT + 2); end
    finish_resp();
    checks++; if (rd_cnt - r0 !== LAT || wr_cnt - w0 !== 1) begin failures++; $display("FAIL sb_cycles got rd=%0d wr=%0d want %0d/1", rd_cnt - r0, wr_cnt - w0, LAT); end
    checks++; if (wr_data !== 32'h1122_33AA || wr_addr !== 32'd7) begin failures++; $display("FAIL sb_merge got=%h@%h want=112233aa@7", wr_data, wr_addr); end
    checks++; if (both_cnt !== b0) begin failures++; $display("FAIL sb_overlap got=%0d want=%0d", both_cnt, b0); end
    ref_mem[7] = 32'h1122_33AA;
  endtask

  task automatic test_misaligned();
    int lat, r0, w0, b0;
    logic err;
    issue(1'b0, 2'd2, 1'b0, 32'h0E, 32'd0, lat, r0, w0, b0); err = resp_error;
    finish_resp();
    checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL lw_misal got lat=%0d err=%b want 1/1", lat, err); end
    checks++; if (rd_cnt !== r0 || wr_cnt !== w0) begin failures++; $display("FAIL lw_misal_mem got rd=%0d wr=%0d want 0/0", rd_cnt - r0, wr_cnt - w0); end
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, r0, w0, b0); err = resp_error;
    finish_resp();
    checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL size11 got lat=%0d err=%b want 1/1", lat, err); end
    checks++; if (rd_cnt !== r0 || wr_cnt !== w0) begin failures++; $display("FAIL size11_mem got rd=%0d wr=%0d want 0/0", rd_cnt - r0, wr_cnt - w0); end
  endtask

  task automatic test_back_pressure();
    int lat, r0, w0, b0;
    logic [31:0] exp_rd;
    exp_rd = ref_load(ref_mem[7], 0, 2'd1, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h1C, 32'd0, lat, r0, w0, b0);
    checks++; if (lat !== LAT + 1) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT + 1); end
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want 1/%h/0", i, resp_valid, resp_rdata, req_ready, exp_rd); end
    end
    req_valid = 1'b0;
    finish_resp();
    checks++; if (rd_cnt - r0 !== LAT || wr_cnt !== w0) begin failures++; $display("FAIL bp_cycles got rd=%0d wr=%0d want %0d/0", rd_cnt - r0, wr_cnt - w0, LAT); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b want=1", req_ready); end
  endtask

  task automatic test_reset_mid();
    int lat, r0, w0, b0;
    int w_start;
    logic [31:0] rd;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h1D; req_wdata = 32'h77;
    w_start = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (MemRead !== 1'b1) begin failures++; $display("FAIL rm_in_rd got=%b want=1", MemRead); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Address !== 32'd0 || WriteData !== 32'd0) begin failures++; $display("FAIL rm_outputs got=%b/%b/%h/%h want 0/0/0/0", MemRead, MemWrite, Address, WriteData); end
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rm_handshake got v=%b rdy=%b want 0/0", resp_valid, req_ready); end
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b want=1", req_ready); end
    checks++; if (wr_cnt !== w_start) begin failures++; $display("FAIL rm_no_write got=%0d want=%0d", wr_cnt - w_start, 0); end
    issue(1'b0, 2'd2, 1'b0, 32'h1C, 32'd0, lat, r0, w0, b0); rd = resp_rdata;
    finish_resp();
    checks++; if (rd !== ref_mem[7]) begin failures++; $display("FAIL rm_mem_intact got=%h want=%h", rd, ref_mem[7]); end
  endtask

  task automatic test_random();
    int lat, r0, w0, b0, idx, off;
    logic w, sg, err, misal;
    logic [1:0] sz;
    logic [31:0] a, wd, rd, exp_rd, exp_word;
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 63)); wd = $urandom;
      idx = int'(a) / 4; off = int'(a) % 4;
      misal = ref_misal(sz, a);
      exp_rd = (!w && !misal) ? ref_load(ref_mem[idx], off, sz, sg) : 32'd0;
      exp_word = ref_store(ref_mem[idx], off, sz, wd);
      issue(w, sz, sg, a, wd, lat, r0, w0, b0);
      rd = resp_rdata; err = resp_error;
      finish_resp();
      $display("txn %0d w=%0d sz=%0d sg=%0d addr=%h wd=%h rdata=%h err=%0d lat=%0d", t, w, sz, sg, a, wd, rd, err, lat);
      checks++; if (rd !== exp_rd || err !== misal) begin failures++; $display("FAIL rnd%0d_resp got=%h/%b want=%h/%b", t, rd, err, exp_rd, misal); end
      checks++; if (lat !== exp_lat(w, sz, a)) begin failures++; $display("FAIL rnd%0d_lat got=%0d want=%0d", t, lat, exp_lat(w, sz, a)); end
      if (w && !misal) begin
        checks++; if (wr_cnt - w0 !== 1 || wr_data !== exp_word) begin failures++; $display("FAIL rnd%0d_store got=%h n=%0d want=%h n=1", t, wr_data, wr_cnt - w0, exp_word); end
        ref_mem[idx] = exp_word;
      end else begin
        checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL rnd%0d_nowrite got=%0d want=0", t, wr_cnt - w0); end
      end
    end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL rnd_overlap got=%0d want=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_loads();
    test_rmw();
    test_misaligned();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
